// File: rtl/uart_tx_loop.sv
// Byte loopback transmitter: captures bytes on tcmd rising edges into a small
// FIFO and serialises them as 8N1 UART frames at OSR clocks per bit.
module uart_tx_loop #(
  parameter int OSR   = 16,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tcmd,
  input  logic [7:0] datapool,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cycCnt_q, cycCnt_d;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            tcmdPrev_q;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      fifoMem [DEPTH];

  logic            detect;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;
  logic            cycLast;

  assign detect  = tcmd & ~tcmdPrev_q;
  assign full    = (count_q == (AW+1)'(DEPTH));
  // A write into a full FIFO is still accepted when the FSM pops in the same cycle.
  assign push    = detect & (~full | pop);
  assign drop    = detect & full & ~pop;
  assign cycLast = (cycCnt_q == CW'(OSR - 1));

  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcmdPrev_q <= 1'b0;
      overflow_q <= 1'b0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      tcmdPrev_q <= tcmd;
      overflow_q <= overflow_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr_q] <= datapool;
    end
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_comb begin
    state_d  = state_q;
    cycCnt_d = cycCnt_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop      = 1'b1;
          shift_d  = fifoMem[rdPtr_q];
          cycCnt_d = '0;
          bitCnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cycLast) begin
          cycCnt_d = '0;
          state_d  = DATA;
        end else begin
          cycCnt_d = cycCnt_q + CW'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (cycLast) begin
          cycCnt_d = '0;
          shift_d  = {1'b0, shift_q[7:1]};
          if (bitCnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end else begin
          cycCnt_d = cycCnt_q + CW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cycLast) begin
          cycCnt_d = '0;
          state_d  = IDLE;
        end else begin
          cycCnt_d = cycCnt_q + CW'(1);
        end
      end
      default: begin
        tx_d     = 1'b1;
        cycCnt_d = '0;
        bitCnt_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cycCnt_q <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cycCnt_q <= cycCnt_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) || (count_q != '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_loop.sv
// Directed bench for uart_tx_loop: decodes frames off tx and checks latency,
// ordering, spacing, overflow, hold-high behaviour and mid-frame reset.
module tb_uart_tx_loop;

  localparam int OSR = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tcmd;
  logic [7:0] datapool;
  logic       tx;
  logic       busy;
  logic       overflow;

  int vectors = 0;
  int misses  = 0;
  int cycle   = 0;
  int starts [6];

  uart_tx_loop #(.OSR(OSR), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .tcmd     (tcmd),
    .datapool (datapool),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One detection every three cycles: tcmd high for one cycle, low for two.
  task automatic applyStimulus(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      datapool = first + 8'(i);
      tcmd     = 1'b1;
      @(negedge clk);
      tcmd = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic waitTxLow(input int budget, output bit found);
    for (int i = 0; i < budget && tx !== 1'b0; i++) @(negedge clk);
    found = (tx === 1'b0);
  endtask

  task automatic recvFrame(input int budget, output bit found, output logic [7:0] data,
                           output int startCyc, output bit clean);
    logic [9:0] frame;
    logic       v;
    frame    = '0;
    data     = '0;
    startCyc = 0;
    clean    = 1'b0;
    waitTxLow(budget, found);
    if (found) begin
      startCyc = cycle;
      clean    = 1'b1;
      for (int b = 0; b < 10; b++) begin
        v = tx;
        for (int c = 0; c < OSR; c++) begin
          if (tx !== v) clean = 1'b0;
          @(negedge clk);
        end
        frame[b] = v;
      end
      if (frame[0] !== 1'b0 || frame[9] !== 1'b1) clean = 1'b0;
      data = frame[8:1];
    end
  endtask

  task automatic expectFrame(input string tag, input logic [7:0] expByte, output int startCyc);
    bit         found;
    bit         clean;
    logic [7:0] data;
    recvFrame(600, found, data, startCyc, clean);
    checkOutput({tag, " found"}, 32'(found), 32'd1);
    if (found) begin
      checkOutput({tag, " data"}, 32'(data), 32'(expByte));
      checkOutput({tag, " framing"}, 32'(clean), 32'd1);
    end
  endtask

  initial begin
    bit found;
    int s;

    rst      = 1'b1;
    tcmd     = 1'b0;
    datapool = 8'h00;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      checkOutput("reset idle tx/busy/ovf", 32'({tx, busy, overflow}), 32'b100);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle after release", 32'({tx, busy, overflow}), 32'b100);

    $display("[TB] single byte 0xA5 latency and framing");
    datapool = 8'hA5;
    tcmd     = 1'b1;
    @(negedge clk);
    tcmd     = 1'b0;
    datapool = 8'h00;
    checkOutput("latency edge1 tx", 32'(tx), 32'd1);
    @(negedge clk);
    checkOutput("latency edge2 tx", 32'(tx), 32'd1);
    checkOutput("busy in start", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("latency edge3 tx", 32'(tx), 32'd0);
    expectFrame("A5", 8'hA5, s);
    checkOutput("busy after frame", 32'(busy), 32'd0);
    checkOutput("tx idle after frame", 32'(tx), 32'd1);

    $display("[TB] four back-to-back bytes");
    fork
      applyStimulus(8'h01, 4);
      begin
        for (int i = 0; i < 4; i++) expectFrame("b2b", 8'h01 + 8'(i), starts[i]);
      end
    join
    for (int i = 0; i < 3; i++) checkOutput("b2b spacing", 32'(starts[i+1] - starts[i]), 32'd161);
    checkOutput("b2b overflow", 32'(overflow), 32'd0);
    checkOutput("b2b busy end", 32'(busy), 32'd0);

    $display("[TB] six bytes into depth-4 fifo");
    fork
      applyStimulus(8'h11, 6);
      begin
        for (int i = 0; i < 5; i++) expectFrame("ovf", 8'h11 + 8'(i), starts[i]);
      end
    join
    checkOutput("ovf spacing", 32'(starts[4] - starts[3]), 32'd161);
    checkOutput("ovf flag", 32'(overflow), 32'd1);
    waitTxLow(400, found);
    checkOutput("ovf no sixth frame", 32'(found), 32'd0);
    checkOutput("ovf busy end", 32'(busy), 32'd0);

    $display("[TB] tcmd held high with changing data");
    fork
      begin
        datapool = 8'h3C;
        tcmd     = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          datapool = datapool + 8'h17;
        end
        tcmd = 1'b0;
      end
      expectFrame("hold", 8'h3C, s);
    join
    waitTxLow(400, found);
    checkOutput("hold single frame", 32'(found), 32'd0);
    checkOutput("overflow sticky", 32'(overflow), 32'd1);

    $display("[TB] reset during data bit 3");
    fork
      applyStimulus(8'hC3, 3);
      waitTxLow(50, found);
    join_any
    checkOutput("rst frame started", 32'(found), 32'd1);
    s = cycle;
    wait fork;
    for (int i = 0; i < 200 && cycle < s + 72; i++) @(negedge clk);
    checkOutput("pre-reset bit3", 32'(tx), 32'd0);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset tx", 32'(tx), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    waitTxLow(400, found);
    checkOutput("no frame after reset", 32'(found), 32'd0);
    checkOutput("busy after reset", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
